// File: rtl/keymgr_pkg.sv
// Shared key manager types and constants.
// Sideload key bundle and packer state encoding.
package keymgr_pkg;

    localparam int KeyWidth  = 256;
    localparam int NumShares = 2;
    localparam int FillCntW  = 5;

    typedef struct packed {
        logic                                valid;
        logic [NumShares-1:0][KeyWidth-1:0] key;
    } hw_key_req_t;

    typedef enum logic {
        Fill  = 1'b0,
        Valid = 1'b1
    } packer_state_e;

endpackage

// File: rtl/keymgr_key_packer.sv
// Serial-to-parallel packer for the two-share sideload key.
// Words fill share 0 then share 1; the key is held until cleared.
module keymgr_key_packer
    import keymgr_pkg::*;
#(
    parameter int NumRegsKey   = 8,
    parameter int NumSharesKey = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                word_valid_i,
    input  logic [31:0]         word_data_i,
    output logic                word_ready_o,
    input  logic                clear_i,
    output hw_key_req_t         key_o,
    output logic [FillCntW-1:0] fill_cnt_o
);

    localparam int NumWords = NumRegsKey * NumSharesKey;
    localparam int WordIdxW = $clog2(NumWords);
    localparam logic [FillCntW-1:0] LastIdx = FillCntW'(NumWords - 1);

    if (NumRegsKey * 32 != KeyWidth) begin : g_bad_regs
        $error("NumRegsKey*32 must equal KeyWidth");
    end
    if (NumSharesKey != NumShares) begin : g_bad_shares
        $error("NumSharesKey must equal NumShares");
    end

    packer_state_e                   state_q;
    logic [FillCntW-1:0]             fill_cnt_q;
    logic                            valid_q;
    logic [NumShares*KeyWidth-1:0]   key_q;
    logic [NumWords-1:0]             word_we;
    logic                            accept;
    logic                            wipe;

    assign wipe         = rst_i || clear_i;
    assign word_ready_o = (state_q == Fill) && !clear_i && !rst_i;
    assign accept       = word_valid_i && word_ready_o;

    // Decode the fill counter into a one-hot word write enable.
    always_comb begin
        word_we = '0;
        if (accept) begin
            word_we[fill_cnt_q[WordIdxW-1:0]] = 1'b1;
        end
    end

    // Fill/Valid control; valid rises on the edge that stores the last word.
    always_ff @(posedge clk_i) begin
        if (wipe) begin
            state_q    <= Fill;
            fill_cnt_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            unique case (state_q)
                Fill: begin
                    if (accept) begin
                        fill_cnt_q <= fill_cnt_q + FillCntW'(1);
                        if (fill_cnt_q == LastIdx) begin
                            state_q <= Valid;
                            valid_q <= 1'b1;
                        end
                    end
                end
                Valid: begin
                    state_q <= Valid;
                end
                default: begin
                    state_q <= Fill;
                end
            endcase
        end
    end

    // Key datapath; a wipe zeroes every word so no partial fill survives.
    always_ff @(posedge clk_i) begin
        if (wipe) begin
            key_q <= '0;
        end else begin
            for (int w = 0; w < NumWords; w++) begin
                if (word_we[w]) begin
                    key_q[w*32 +: 32] <= word_data_i;
                end
            end
        end
    end

    assign key_o.valid = valid_q;
    assign key_o.key   = key_q;
    assign fill_cnt_o  = fill_cnt_q;

endmodule

// File: doc/keymgr_key_packer.md
# keymgr_key_packer

Serial-to-parallel packer that builds a `keymgr_pkg::hw_key_req_t` sideload key from a stream of 32-bit words. It sits on the key manager's sideload output, upstream of the consumers that split the key back into per-share 32-bit registers. It accepts share 0 words 0..7, then share 1 words 0..7. It then presents the full two-share key with `valid` set until it is explicitly cleared.

## Interface
Parameters:
- `NumRegsKey`, 8: 32-bit words per share; elaboration error unless `NumRegsKey*32 == 256`.
- `NumSharesKey`, 2: shares per key; elaboration error unless it equals 2.

Ports:
- `clk_i`  input  1  clock; single clock domain.
- `rst_i`  input  1  reset, synchronous, active-high.
- `word_valid_i`  input  1  an input word is offered.
- `word_data_i`  input  32  input word.
- `word_ready_o`  output  1  the packer can accept a word this cycle.
- `clear_i`  input  1  wipe the key and restart the fill.
- `key_o`  output  `hw_key_req_t`  packed key; `.valid` qualifies `.key`.
- `fill_cnt_o`  output  5  words accepted since the last reset or clear (0..16).

## Operation
- A word is accepted on a rising edge when `word_valid_i && word_ready_o`.
- Accepted word number n (0-based) is written to `key_o.key[n / NumRegsKey][(n % NumRegsKey)*32 +: 32]`.
  - Share index is the upper bit of n; word index is the lower 3 bits.
- State machine, two states:
  - `Fill`, the reset state: `word_ready_o = !clear_i && !rst_i`. Accepting word 15 moves to `Valid`.
  - `Valid`: `word_ready_o = 0`, `key_o.valid = 1`, and the key is held stable. Input words are back-pressured, never dropped.
- `clear_i`, in either state: on the next edge, `key_o.key` is zeroed, `key_o.valid` goes to 0, `fill_cnt_o` goes to 0, and the state returns to `Fill`.
- `clear_i` together with `word_valid_i`: clear wins. Ready is low, so no word is accepted.
- Partial fill followed by `clear_i`: all previously written words are zeroed. Nothing from the partial fill survives.
- `rst_i` mid-fill or in `Valid`: same effect as `clear_i`, and it overrides everything.
- `fill_cnt_o` saturates at 16 in `Valid`. It never wraps.
- Unwritten key bits read as 0 during `Fill`.
- `key_o.valid` is never 1 while any word of the current fill is unwritten.

## Timing
- Reset values, on the edge with `rst_i = 1`:
  - `key_o.valid = 0` and `key_o.key = 0`.
  - `fill_cnt_o = 0` and state `Fill`.
  - `word_ready_o = 0` while `rst_i` is high, then 1 on the cycle after.
- Write latency: a word accepted at edge k is visible on `key_o.key` and in `fill_cnt_o` from edge k onward, i.e. in the following cycle.
- `key_o.valid` rises at the same edge that registers word 15; there is no extra cycle.
- Throughput is one word per cycle. The minimum time from reset release to valid is 16 accepted cycles.
- `word_ready_o` is combinational from the state, `clear_i` and `rst_i` only. It has no dependency on `word_valid_i` or `word_data_i`.
- `clear_i` from `Valid`: `key_o.valid` falls at the next edge, and `word_ready_o` is 1 in the following cycle if `clear_i` has deasserted.
- All outputs are registered except `word_ready_o`.

## Structure
- `keymgr_pkg` holds:
  - `hw_key_req_t` (`valid`, `[1:0][255:0] key`).
  - Constants `KeyWidth = 256` and `NumShares = 2`.
  - `FillCntW = 5` and the state enum `packer_state_e {Fill, Valid}`.
- The module's parameter checks compare against these package constants.
- Single module with no sub-module. The datapath is one 512-bit register with a per-word write enable decoded from the fill counter.

## Test plan
- Reset, then 16 back-to-back words `32'h1000_0000 + n` → the cycle after the last accept:
  - `key_o.valid = 1`.
  - `key_o.key[0][31:0] = 32'h1000_0000`, `key_o.key[1][255:224] = 32'h1000_000F`.
  - `fill_cnt_o = 16`, `word_ready_o = 0`.
- Random `word_valid_i` gaps, with `word_valid_i` held high for 4 cycles in `Valid` → key identical to the gap-free run, and no word lost or duplicated across the gaps or in `Valid`.
- 5 words `32'hA5A5_A5A5`, then `clear_i` for 1 cycle → `key_o.key == 0` and `fill_cnt_o == 0`. Then 16 words `32'h0000_0001` → valid, with every 32-bit field equal to 1.
- `clear_i` and `word_valid_i` asserted in the same cycle at `fill_cnt_o = 7` → no accept, and `fill_cnt_o = 0` next cycle.
- `rst_i` pulsed while in `Valid` → the next cycle has `key_o.valid = 0` and `key_o.key = 0`, and `word_ready_o = 1` one cycle after `rst_i` falls.
- Scoreboard check: unpack `key_o` as `key[s][i*32 +: 32]` for s < 2, i < 8 → equals input word s*8 + i for 100 random keys.
